m_wb_initiator: RTL and testbench



---
 rtl/m_wb_initiator_pkg.sv | 47 ++++
 rtl/m_wb_initiator_watchdog.sv | 32 +++
 rtl/m_wb_initiator.sv | 156 +++++++++++++++
 tb/tb_m_wb_initiator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_wb_initiator_pkg.sv
// Shared definitions for the scripted Wishbone classic initiator: FSM state
// encodings, the addresses of the existing responders, and the register
// bundles carried by the initiator core.
package m_wb_initiator_pkg;

   // Initiator FSM states. The encodings are fixed because harness software
   // and waveform decoders rely on them.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Base addresses of the responders currently on the harness bus.
   localparam logic [31:0] SIMPLE_REG_BASE = 32'h6000_0004;
   localparam logic [31:0] DYN_REG_BASE    = 32'h6000_0010;

   // Registered Wishbone request. CYC_O and STB_O are both driven from cyc.
   typedef struct packed {
      logic        cyc;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wb_req_t;

   // Registered response fields. The wait count lives outside the struct
   // because its width is a module parameter.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] dat;
   } rsp_t;

   // Read data returned to the command side: writes always report zero so
   // the caller never sees stale bus data.
   function automatic logic [31:0] read_data(input logic we, input logic [31:0] bus_dat);
      return we ? 32'h0000_0000 : bus_dat;
   endfunction

   // True for addresses that currently have a responder behind them. Useful
   // for harness code that wants to skip the watchdog path deliberately.
   function automatic logic is_known_responder(input logic [31:0] adr);
      return (adr == SIMPLE_REG_BASE) || (adr == DYN_REG_BASE);
   endfunction

endpackage

// File: rtl/m_wb_initiator_watchdog.sv
// Wait/timeout counter for a Wishbone cycle. Counts strobe cycles without an
// acknowledge and flags when the configured limit is reached. The counter
// saturates at the limit so it can never wrap back to a small value.
module m_wb_initiator_watchdog #(
   parameter int TOW     = 8,
   parameter int TIMEOUT = 255
) (
   input  logic           CLK_I,
   input  logic           RST_I,
   input  logic           clr,
   input  logic           en,
   output logic [TOW-1:0] count,
   output logic           hit
);

   localparam logic [TOW-1:0] LIMIT = TOW'(TIMEOUT);

   assign hit = (count == LIMIT);

   // Counter: cleared on reset or at the start of a cycle, advanced once per
   // unacknowledged strobe cycle, held once the limit is reached.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge; reset is synchronous here.
   always_ff @(posedge CLK_I) begin
      if (RST_I || clr) begin
         count <= '0;
      end else if (en && !hit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/m_wb_initiator.sv
// Scripted Wishbone classic initiator. Accepts one command at a time over a
// valid/ready handshake, runs exactly one single-beat Wishbone cycle for it,
// and returns read data, a timeout flag and the number of wait cycles.
// Every output except cmd_ready is registered.
module m_wb_initiator
   import m_wb_initiator_pkg::*;
#(
   parameter int TOW     = 8,
   parameter int TIMEOUT = 255
) (
   input  logic           CLK_I,
   input  logic           RST_I,
   // command side
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic           cmd_we,
   input  logic [31:0]    cmd_adr,
   input  logic [31:0]    cmd_dat,
   input  logic [3:0]     cmd_sel,
   // response side
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [31:0]    rsp_dat,
   output logic           rsp_err,
   output logic [TOW-1:0] rsp_wait,
   // Wishbone classic initiator port
   output logic           CYC_O,
   output logic           STB_O,
   output logic           WE_O,
   output logic [31:0]    ADR_O,
   output logic [31:0]    DAT_O,
   output logic [3:0]     SEL_O,
   input  logic           ACK_I,
   input  logic [31:0]    DAT_I
);

   state_t         state_q;
   state_t         state_d;
   wb_req_t        req_q;
   wb_req_t        req_d;
   rsp_t           rsp_q;
   rsp_t           rsp_d;
   logic [TOW-1:0] wait_q;
   logic [TOW-1:0] wait_d;

   logic [TOW-1:0] wd_count;
   logic           wd_hit;
   logic           wd_clr;
   logic           wd_en;

   // Ready depends on state and reset only, never on cmd_valid, so a caller
   // may wait for ready before presenting a command.
   assign cmd_ready = (state_q == ST_IDLE) && !RST_I;

   m_wb_initiator_watchdog #(
      .TOW     (TOW),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .clr   (wd_clr),
      .en    (wd_en),
      .count (wd_count),
      .hit   (wd_hit)
   );

   // State register.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> BUS on accept, BUS -> RESP on ack or
   // timeout, RESP -> IDLE once the response is consumed.
   // NOTE: every variable written in a combinational block gets a default at
   // the top so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (cmd_valid)             state_d = ST_BUS;
         ST_BUS:  if (ACK_I || wd_hit)       state_d = ST_RESP;
         ST_RESP: if (rsp_ready)             state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // Output logic: computes the next value of every registered output.
   // Address, data and selects are left untouched after a cycle ends, so
   // responders must qualify with STB_O. ACK_I outside BUS is ignored.
   always_comb begin
      req_d  = req_q;
      rsp_d  = rsp_q;
      wait_d = wait_q;
      wd_clr = 1'b0;
      wd_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               req_d  = '{cyc: 1'b1, we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
               wd_clr = 1'b1;
            end
         end
         ST_BUS: begin
            if (ACK_I) begin
               // Acknowledge wins over a timeout on the same edge.
               req_d.cyc = 1'b0;
               req_d.we  = 1'b0;
               rsp_d     = '{valid: 1'b1, err: 1'b0, dat: read_data(req_q.we, DAT_I)};
               wait_d    = wd_count;
            end else if (wd_hit) begin
               req_d.cyc = 1'b0;
               req_d.we  = 1'b0;
               rsp_d     = '{valid: 1'b1, err: 1'b1, dat: 32'h0000_0000};
               wait_d    = wd_count;
            end else begin
               wd_en = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_d.valid = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Output registers. Reset drops the bus cycle immediately and discards
   // any response that was still being collected.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         req_q  <= '0;
         rsp_q  <= '0;
         wait_q <= '0;
      end else begin
         req_q  <= req_d;
         rsp_q  <= rsp_d;
         wait_q <= wait_d;
      end
   end

   assign CYC_O     = req_q.cyc;
   assign STB_O     = req_q.cyc;
   assign WE_O      = req_q.we;
   assign ADR_O     = req_q.adr;
   assign DAT_O     = req_q.dat;
   assign SEL_O     = req_q.sel;
   assign rsp_valid = rsp_q.valid;
   assign rsp_err   = rsp_q.err;
   assign rsp_dat   = rsp_q.dat;
   assign rsp_wait  = wait_q;

endmodule

// File: tb/tb_m_wb_initiator.sv
// Directed bench for m_wb_initiator. The bench plays the Wishbone responder
// itself: it holds small models of the simple and dynamic registers and
// acknowledges after a chosen number of strobe cycles (or never).
module tb_m_wb_initiator;
   import m_wb_initiator_pkg::*;

   localparam int TOW     = 8;
   localparam int TIMEOUT = 255;

   logic           CLK_I = 1'b0;
   logic           RST_I;
   logic           cmd_valid;
   logic           cmd_ready;
   logic           cmd_we;
   logic [31:0]    cmd_adr;
   logic [31:0]    cmd_dat;
   logic [3:0]     cmd_sel;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [31:0]    rsp_dat;
   logic           rsp_err;
   logic [TOW-1:0] rsp_wait;
   logic           CYC_O;
   logic           STB_O;
   logic           WE_O;
   logic [31:0]    ADR_O;
   logic [31:0]    DAT_O;
   logic [3:0]     SEL_O;
   logic           ACK_I;
   logic [31:0]    DAT_I;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] mem_simple;
   logic [31:0] mem_dyn;

   always #5 CLK_I = ~CLK_I;

   m_wb_initiator #(
      .TOW     (TOW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK_I     (CLK_I),
      .RST_I     (RST_I),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat),
      .rsp_err   (rsp_err),
      .rsp_wait  (rsp_wait),
      .CYC_O     (CYC_O),
      .STB_O     (STB_O),
      .WE_O      (WE_O),
      .ADR_O     (ADR_O),
      .DAT_O     (DAT_O),
      .SEL_O     (SEL_O),
      .ACK_I     (ACK_I),
      .DAT_I     (DAT_I)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer a command and wait (bounded) until the edge that accepts it.
   // Returns at the falling edge after the accepting rising edge.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge CLK_I);
         n++;
      end
      check("accept_ready", {31'b0, cmd_ready}, 32'd1);
      @(negedge CLK_I);
      cmd_valid = 1'b0;
   endtask

   // Act as responder: ack in the strobe cycle with index lat (0 = first
   // cycle), or never when lat < 0. Reports how many cycles STB_O was high.
   task automatic serve(input int lat, input logic [31:0] rdata, output int stb_cycles);
      stb_cycles = 0;
      while (STB_O === 1'b1 && stb_cycles < 400) begin
         if (stb_cycles == lat) begin
            ACK_I = 1'b1;
            DAT_I = rdata;
         end
         stb_cycles++;
         @(negedge CLK_I);
         ACK_I = 1'b0;
         DAT_I = 32'hA5A5_5A5A;
      end
   endtask

   // One complete command: issue, check the request on the bus, respond,
   // then check the response (left unconsumed).
   task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int lat,
                          input int exp_stb, input logic exp_err,
                          input logic [31:0] exp_wait, input logic [31:0] exp_dat);
      int          stb;
      logic [31:0] rdata;
      if (adr == DYN_REG_BASE)         rdata = mem_dyn;
      else if (adr == SIMPLE_REG_BASE) rdata = mem_simple;
      else                             rdata = 32'hBAD0_BAD0;
      issue(we, adr, dat, sel);
      check({tag, "_stb"}, {31'b0, STB_O}, 32'd1);
      check({tag, "_cyc"}, {31'b0, CYC_O}, 32'd1);
      check({tag, "_we"},  {31'b0, WE_O},  {31'b0, we});
      check({tag, "_adr"}, ADR_O, adr);
      check({tag, "_dat_o"}, DAT_O, dat);
      check({tag, "_sel"}, {28'b0, SEL_O}, {28'b0, sel});
      serve(lat, rdata, stb);
      if (we && lat >= 0 && stb == lat + 1) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               if (adr == DYN_REG_BASE)         mem_dyn[8*i +: 8]    = dat[8*i +: 8];
               else if (adr == SIMPLE_REG_BASE) mem_simple[8*i +: 8] = dat[8*i +: 8];
            end
         end
      end
      check({tag, "_stb_cycles"}, stb, exp_stb);
      check({tag, "_cyc_end"}, {31'b0, CYC_O}, 32'd0);
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      check({tag, "_rsp_wait"}, {24'b0, rsp_wait}, exp_wait);
      check({tag, "_rsp_dat"}, rsp_dat, exp_dat);
      check({tag, "_ready_busy"}, {31'b0, cmd_ready}, 32'd0);
   endtask

   task automatic consume(input string tag);
      rsp_ready = 1'b1;
      @(negedge CLK_I);
      rsp_ready = 1'b0;
      check({tag, "_rsp_done"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, "_ready_idle"}, {31'b0, cmd_ready}, 32'd1);
   endtask

   initial begin
      RST_I      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_adr    = 32'h0;
      cmd_dat    = 32'h0;
      cmd_sel    = 4'h0;
      rsp_ready  = 1'b0;
      ACK_I      = 1'b0;
      DAT_I      = 32'h0;
      mem_simple = 32'h0;
      mem_dyn    = 32'h0;

      // Reset state, with a command offered during reset that must be ignored.
      repeat (2) @(negedge CLK_I);
      cmd_valid = 1'b1;
      @(negedge CLK_I);
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_cyc", {31'b0, CYC_O}, 32'd0);
      check("rst_stb", {31'b0, STB_O}, 32'd0);
      check("rst_we", {31'b0, WE_O}, 32'd0);
      check("rst_adr", ADR_O, 32'h0);
      check("rst_dat_o", DAT_O, 32'h0);
      check("rst_sel", {28'b0, SEL_O}, 32'h0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'h0);
      check("rst_rsp_wait", {24'b0, rsp_wait}, 32'h0);
      cmd_valid = 1'b0;
      RST_I     = 1'b0;
      @(negedge CLK_I);
      check("idle_ready", {31'b0, cmd_ready}, 32'd1);

      // Stray acknowledge while idle.
      ACK_I = 1'b1;
      DAT_I = 32'h1234_5678;
      @(negedge CLK_I);
      ACK_I = 1'b0;
      check("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("stray_rsp_dat", rsp_dat, 32'h0);
      check("stray_cyc", {31'b0, CYC_O}, 32'd0);
      check("stray_ready", {31'b0, cmd_ready}, 32'd1);

      // Simple register: single-cycle ack, write then read back.
      run_cmd("wr_simple", 1'b1, SIMPLE_REG_BASE, 32'h0000_0302, 4'hF, 0, 1, 1'b0, 32'd0, 32'h0);
      consume("wr_simple");
      check("adr_held", ADR_O, SIMPLE_REG_BASE);
      check("dat_held", DAT_O, 32'h0000_0302);
      run_cmd("rd_simple", 1'b0, SIMPLE_REG_BASE, 32'hFFFF_FFFF, 4'hF, 0, 1, 1'b0, 32'd0, 32'h0000_0302);
      consume("rd_simple");

      // Dynamic register: write latency 2, read latency 3.
      run_cmd("wr_dyn", 1'b1, DYN_REG_BASE, 32'hDEAD_BEEF, 4'hF, 2, 3, 1'b0, 32'd2, 32'h0);
      consume("wr_dyn");
      run_cmd("rd_dyn", 1'b0, DYN_REG_BASE, 32'h0, 4'hF, 3, 4, 1'b0, 32'd3, 32'hDEAD_BEEF);
      consume("rd_dyn");

      // Unmapped address: watchdog abort after 256 strobe cycles.
      run_cmd("rd_unmapped", 1'b0, 32'h7000_0000, 32'h0, 4'hF, -1, 256, 1'b1, 32'd255, 32'h0);
      consume("rd_unmapped");

      // Response backpressure with a new command waiting.
      run_cmd("rd_hold", 1'b0, SIMPLE_REG_BASE, 32'h0, 4'hF, 0, 1, 1'b0, 32'd0, 32'h0000_0302);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_adr   = SIMPLE_REG_BASE;
      cmd_dat   = 32'h0000_00AA;
      cmd_sel   = 4'h1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK_I);
         check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("hold_rsp_dat", rsp_dat, 32'h0000_0302);
         check("hold_rsp_wait", {24'b0, rsp_wait}, 32'd0);
         check("hold_rsp_err", {31'b0, rsp_err}, 32'd0);
         check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         check("hold_stb", {31'b0, STB_O}, 32'd0);
      end
      consume("rd_hold");
      check("hold_release_stb", {31'b0, STB_O}, 32'd0);
      // Byte-select write of the low byte only, then read it back.
      run_cmd("wr_sel", 1'b1, SIMPLE_REG_BASE, 32'h0000_00AA, 4'h1, 0, 1, 1'b0, 32'd0, 32'h0);
      consume("wr_sel");
      run_cmd("rd_sel", 1'b0, SIMPLE_REG_BASE, 32'h0, 4'hF, 0, 1, 1'b0, 32'd0, 32'h0000_03AA);
      consume("rd_sel");

      // Reset two cycles into a dynamic-register read.
      issue(1'b0, DYN_REG_BASE, 32'h0, 4'hF);
      @(negedge CLK_I);
      check("mid_stb", {31'b0, STB_O}, 32'd1);
      RST_I = 1'b1;
      @(negedge CLK_I);
      check("mid_rst_cyc", {31'b0, CYC_O}, 32'd0);
      check("mid_rst_stb", {31'b0, STB_O}, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      RST_I = 1'b0;
      ACK_I = 1'b1;
      DAT_I = 32'h5555_AAAA;
      @(negedge CLK_I);
      ACK_I = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("mid_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         check("mid_after_cyc", {31'b0, CYC_O}, 32'd0);
         @(negedge CLK_I);
      end
      run_cmd("rd_after_rst", 1'b0, DYN_REG_BASE, 32'h0, 4'hF, 3, 4, 1'b0, 32'd3, 32'hDEAD_BEEF);
      consume("rd_after_rst");

      // Acknowledge on the same edge the counter reaches TIMEOUT.
      run_cmd("rd_same_edge", 1'b0, DYN_REG_BASE, 32'h0, 4'hF, TIMEOUT, TIMEOUT + 1, 1'b0,
              32'd255, 32'hDEAD_BEEF);
      consume("rd_same_edge");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
